etc_planar_block_generator: RTL and testbench
=============================================

Name: etc_planar_block_generator

Overview:
- Parametrised successor to the per-pixel planar generator in the ETC2 RGB decode path.
- Accepts one decoded planar block (base colours O, H, V) over a valid/ready handshake and streams all 16 pixels, one per cycle.
- Output pipeline is 2 register stages with full back-pressure.
- Channel width and channel count (RGB or planar RGBA) are generic.
- Sits between the planar mode unpacker and the pixel writer.

Parameters:
- CH_W, 8, bits per colour channel.
- NUM_CH, 3, channels per base colour: 3 = RGB, 4 = RGBA with planar alpha. Channel k occupies bits [k*CH_W +: CH_W]; channel 0 = R.
- ROW_MAJOR, 0, pixel emission order: 0 = column-major, p = x*4+y; 1 = row-major, p = y*4+x.

Ports:
- sclk  in  1  clock.
- rsrt  in  1  synchronous active-high reset.
- blk_valid  in  1  block offered.
- blk_ready  out  1  block can be accepted.
- blk_alpha  in  1  NUM_CH==3 only: 1 = alpha all-ones, 0 = alpha zero.
- blk_c0  in  NUM_CH*CH_W  base colour O.
- blk_c1  in  NUM_CH*CH_W  base colour H.
- blk_c2  in  NUM_CH*CH_W  base colour V.
- pix_valid  out  1  pixel present.
- pix_ready  in  1  downstream accepts pixel.
- pix_idx  out  4  pixel index p, always reported in the column-major (x*4+y) form.
- pix_color  out  NUM_CH*CH_W  interpolated channels.
- pix_a  out  CH_W  alpha: channel 3 when NUM_CH==4, else constant from blk_alpha.
- pix_last  out  1  final pixel of block.

Behaviour:
- Clock and reset: one clock, sclk; reset rsrt is synchronous, active-high.
- Reset:
  - state=IDLE, counter=0, both pipeline stages invalid.
  - pix_valid, pix_last, pix_idx, pix_color, pix_a all 0.
  - blk_ready = (state==IDLE), so it is 1 during and after reset. blk_valid is ignored while rsrt=1.
- FSM IDLE:
  - blk_ready=1.
  - On blk_valid: latch c0/c1/c2/blk_alpha, clear counter, go to EMIT.
- FSM EMIT:
  - blk_ready=0.
  - Each cycle stage A accepts, issue counter n into stage A and increment n.
  - When n==15 is issued, go to IDLE next cycle.
  - This gives exactly one bubble between back-to-back blocks; block period is 17 cycles with pix_ready held high.
- Coordinates: ROW_MAJOR=0 gives x=n[3:2], y=n[1:0]. ROW_MAJOR=1 gives y=n[3:2], x=n[1:0]. pix_idx = {x,y}.
- Arithmetic (stage A, per channel):
  - S = x*(H-O) + y*(V-O) + 4*O + 2, computed in CH_W+5 bit signed with zero-extended operands.
- Stage B:
  - v = S >>> 2 (arithmetic shift, floor).
  - Clamp to [0, 2^CH_W-1].
  - Register into the output.
- Latency: block accepted in cycle T → pixel 0 has pix_valid=1 in cycle T+3.
- Back-pressure:
  - adv = !pix_valid || pix_ready. Both stages and the counter advance only when adv=1.
  - While stalled, all pix_* outputs stay stable.
  - No pixel is dropped or duplicated.
- pix_last=1 exactly with the pixel whose counter was 15, or with the last unmasked pixel under the optional feature.
- Reset mid-block: the next cycle has pix_valid=0, state=IDLE, and no residual pixels. The latched block is discarded.
- Simultaneous reset and blk_valid: reset wins; the block is not accepted.

Optional Feature:
- Macro ETC_PLANAR_PIX_MASK_EN.
- When defined:
  - Adds input pix_mask[15:0], sampled with the block and indexed by pix_idx form p.
  - Pixels with mask bit 0 are skipped: the counter jumps to the next set bit in the same cycle, with no bubble.
  - pix_last marks the last set bit.
  - mask==0: block accepted, no pixels emitted, state stays IDLE.
- When undefined: the port is absent and all 16 pixels are always emitted.

Test Plan:
- Nominal, CH_W=8, NUM_CH=3, pix_ready=1:
  - Stimulus: O=(100,100,100), H=(104,104,104), V=(96,96,96), blk_alpha=1.
  - Response: p=5 → 100, p=12 → 103, p=0 → 100, pix_a=255.
  - 16 pixels in consecutive cycles; first at accept+3; pix_last on p=15.
- Clamp:
  - Stimulus 1: O=250, H=V=255. Response: p=15 → 255 (unclamped 258).
  - Stimulus 2: O=2, H=V=0. Response: p=15 → 0 (unclamped -1), p=0 → 2.
- Back-pressure:
  - Stimulus: drop pix_ready for 5 cycles while pixel 3 is presented.
  - Response: pix_idx=3 and data held stable; the 16 pixels still arrive in order with no duplicates.
- Back-to-back blocks, blk_valid always high:
  - Response: the second block is accepted exactly 17 cycles after the first.
  - Its pixel 0 follows the first block's pix_last after exactly one empty cycle.
- Reset mid-block:
  - Stimulus: assert rsrt for 1 cycle while pixel 7 is on the output.
  - Response: next cycle pix_valid=0, blk_ready=1, no further pixels from that block.
- Mask (ETC_PLANAR_PIX_MASK_EN):
  - Stimulus 1: pix_mask=16'h8001. Response: pixels p=0 and p=15 only, in consecutive cycles, pix_last on p=15.
  - Stimulus 2: pix_mask=0. Response: no pixels, blk_ready stays 1.

Source files
------------

// File: rtl/etc_planar_block_generator.sv
// ---------------------------------------------------------------------------
// etc_planar_block_generator
//
// Purpose:
//   Takes one decoded ETC2 planar block (base colours O, H, V) over a
//   valid/ready handshake and streams its 16 interpolated pixels, one per
//   cycle, through a two-stage output pipeline with full back-pressure.
//   Stage A forms the per-channel planar sum, stage B floors, clamps and
//   registers the result onto the pixel port.
//
// Optional feature (macro ETC_PLANAR_PIX_MASK_EN):
//   Adds pix_mask[15:0], latched with the block and indexed by the
//   column-major pixel index. Masked-off pixels are skipped with no bubble;
//   an all-zero mask accepts the block and emits nothing.
//
// Ports:
//   sclk       clock
//   rsrt       synchronous active-high reset
//   blk_valid  block offered
//   blk_ready  block can be accepted (high while idle)
//   blk_alpha  NUM_CH==3 only: 1 = alpha all-ones, 0 = alpha zero
//   blk_c0     base colour O, channel k at [k*CH_W +: CH_W], channel 0 = R
//   blk_c1     base colour H
//   blk_c2     base colour V
//   pix_mask   (ETC_PLANAR_PIX_MASK_EN only) per-pixel enable
//   pix_valid  pixel present
//   pix_ready  downstream accepts pixel
//   pix_idx    pixel index, always column-major {x,y}
//   pix_color  interpolated channels
//   pix_a      alpha: channel 3 when NUM_CH==4, else constant from blk_alpha
//   pix_last   final pixel of the block
// ---------------------------------------------------------------------------
module etc_planar_block_generator #(
  parameter int CH_W      = 8,
  parameter int NUM_CH    = 3,
  parameter int ROW_MAJOR = 0
) (
  input  logic                   sclk,
  input  logic                   rsrt,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  input  logic                   blk_alpha,
  input  logic [NUM_CH*CH_W-1:0] blk_c0,
  input  logic [NUM_CH*CH_W-1:0] blk_c1,
  input  logic [NUM_CH*CH_W-1:0] blk_c2,
`ifdef ETC_PLANAR_PIX_MASK_EN
  input  logic [15:0]            pix_mask,
`endif
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [3:0]             pix_idx,
  output logic [NUM_CH*CH_W-1:0] pix_color,
  output logic [CH_W-1:0]        pix_a,
  output logic                   pix_last
);

  // Full sum width, and the width kept after the floor-divide by 4.
  localparam int SW = CH_W + 5;
  localparam int QW = SW - 2;
  localparam int CW = NUM_CH * CH_W;

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [CW-1:0]   c0_q, c1_q, c2_q;
  logic            alpha_q;

  logic            a_valid_q, a_last_q, a_alpha_q;
  logic [3:0]      a_idx_q;
  logic [NUM_CH*QW-1:0] a_sum_q;

  logic            pix_valid_q, pix_last_q;
  logic [3:0]      pix_idx_q;
  logic [CW-1:0]   pix_color_q;
  logic [CH_W-1:0] pix_a_q;

  logic            adv_s;
  logic [15:0]     mask_in_s, mask_cur_s;
  logic [15:0]     first_hit_s, nxt_hit_s;
  logic            first_found_s, nxt_found_s;
  logic [3:0]      first_n_s, nxt_n_s;
  logic [1:0]      x_s, y_s;
  logic [NUM_CH*QW-1:0] sum_s;
  logic [CW-1:0]   clamp_s;
  logic [CH_W-1:0] alpha_s;

`ifdef ETC_PLANAR_PIX_MASK_EN
  logic [15:0]     mask_q;
  assign mask_in_s  = pix_mask;
  assign mask_cur_s = mask_q;
`else
  // Without the mask every pixel is enabled; the skip logic folds away.
  assign mask_in_s  = 16'hFFFF;
  assign mask_cur_s = 16'hFFFF;
`endif

  // The whole pipeline moves together: a stalled output freezes everything.
  assign adv_s     = !pix_valid_q || pix_ready;
  assign blk_ready = (state_q == IDLE);

  // Map emission counter n to the column-major pixel index p = {x,y}.
  function automatic logic [3:0] p_of(input logic [3:0] n);
    if (ROW_MAJOR != 0) p_of = {n[1:0], n[3:2]};
    else                p_of = n;
  endfunction

  // Find the first enabled counter value for a new block and the next
  // enabled value after the current one (lowest index wins).
  always_comb begin
    first_hit_s   = 16'h0000;
    nxt_hit_s     = 16'h0000;
    first_n_s     = 4'd0;
    nxt_n_s       = 4'd0;
    first_found_s = 1'b0;
    nxt_found_s   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      first_hit_s[i] = mask_in_s[p_of(4'(i))];
      nxt_hit_s[i]   = (4'(i) > cnt_q) && mask_cur_s[p_of(4'(i))];
    end
    for (int i = 15; i >= 0; i--) begin
      first_n_s = first_hit_s[i] ? 4'(i) : first_n_s;
      nxt_n_s   = nxt_hit_s[i]   ? 4'(i) : nxt_n_s;
    end
    first_found_s = |first_hit_s;
    nxt_found_s   = |nxt_hit_s;
  end

  // Pixel coordinates of the counter value being issued.
  always_comb begin
    if (ROW_MAJOR != 0) begin
      y_s = cnt_q[3:2];
      x_s = cnt_q[1:0];
    end else begin
      x_s = cnt_q[3:2];
      y_s = cnt_q[1:0];
    end
  end

  // Planar sum S = x*(H-O) + y*(V-O) + 4*O + 2 in SW-bit two's complement.
  // Only S[SW-1:2] is kept: dropping the two LSBs of a two's-complement
  // value is exactly the floor-divide by 4.
  always_comb begin
    sum_s = {(NUM_CH*QW){1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      sum_s[k*QW +: QW] = QW'((
          {{(SW-2){1'b0}}, x_s} * ({5'b00000, c1_q[k*CH_W +: CH_W]} - {5'b00000, c0_q[k*CH_W +: CH_W]})
        + {{(SW-2){1'b0}}, y_s} * ({5'b00000, c2_q[k*CH_W +: CH_W]} - {5'b00000, c0_q[k*CH_W +: CH_W]})
        + ({5'b00000, c0_q[k*CH_W +: CH_W]} << 2)
        + {{(SW-2){1'b0}}, 2'b10}) >> 2);
    end
  end

  // Clamp each floored channel into [0, 2^CH_W-1].
  always_comb begin
    clamp_s = {CW{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (a_sum_q[k*QW + QW - 1]) begin
        clamp_s[k*CH_W +: CH_W] = {CH_W{1'b0}};
      end else if (|a_sum_q[k*QW + CH_W +: 2]) begin
        clamp_s[k*CH_W +: CH_W] = {CH_W{1'b1}};
      end else begin
        clamp_s[k*CH_W +: CH_W] = a_sum_q[k*QW +: CH_W];
      end
    end
  end

  if (NUM_CH >= 4) begin : g_alpha_ch
    assign alpha_s = clamp_s[3*CH_W +: CH_W];
  end else begin : g_alpha_const
    assign alpha_s = {CH_W{a_alpha_q}};
  end

  // Block FSM: latch the block while idle, then walk the enabled counters.
  always_ff @(posedge sclk) begin
    if (rsrt) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      c0_q    <= {CW{1'b0}};
      c1_q    <= {CW{1'b0}};
      c2_q    <= {CW{1'b0}};
      alpha_q <= 1'b0;
`ifdef ETC_PLANAR_PIX_MASK_EN
      mask_q  <= 16'h0000;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (blk_valid) begin
            c0_q    <= blk_c0;
            c1_q    <= blk_c1;
            c2_q    <= blk_c2;
            alpha_q <= blk_alpha;
`ifdef ETC_PLANAR_PIX_MASK_EN
            mask_q  <= pix_mask;
`endif
            cnt_q   <= first_n_s;
            // An empty mask consumes the block without leaving IDLE.
            state_q <= first_found_s ? EMIT : IDLE;
          end
        end
        EMIT: begin
          if (adv_s) begin
            if (nxt_found_s) begin
              cnt_q <= nxt_n_s;
            end else begin
              cnt_q   <= 4'd0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-stage pixel pipeline: stage A holds the sum, stage B the output.
  always_ff @(posedge sclk) begin
    if (rsrt) begin
      a_valid_q   <= 1'b0;
      a_last_q    <= 1'b0;
      a_alpha_q   <= 1'b0;
      a_idx_q     <= 4'd0;
      a_sum_q     <= {(NUM_CH*QW){1'b0}};
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      pix_idx_q   <= 4'd0;
      pix_color_q <= {CW{1'b0}};
      pix_a_q     <= {CH_W{1'b0}};
    end else if (adv_s) begin
      a_valid_q <= (state_q == EMIT);
      if (state_q == EMIT) begin
        a_idx_q   <= p_of(cnt_q);
        a_last_q  <= !nxt_found_s;
        a_sum_q   <= sum_s;
        a_alpha_q <= alpha_q;
      end
      pix_valid_q <= a_valid_q;
      pix_last_q  <= a_valid_q && a_last_q;
      if (a_valid_q) begin
        pix_idx_q   <= a_idx_q;
        pix_color_q <= clamp_s;
        pix_a_q     <= alpha_s;
      end
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_idx   = pix_idx_q;
  assign pix_color = pix_color_q;
  assign pix_a     = pix_a_q;
  assign pix_last  = pix_last_q;

endmodule

// File: tb/tb_etc_planar_block_generator.sv
// ---------------------------------------------------------------------------
// Testbench for etc_planar_block_generator (default parameters, RGB 8-bit,
// column-major). Directed table vectors, hand-written multi-cycle sequences
// and randomized blocks with random back-pressure, all checked against a
// plain-arithmetic reference of the planar interpolation.
// ---------------------------------------------------------------------------
module tb_etc_planar_block_generator;

  localparam int CH_W      = 8;
  localparam int NUM_CH    = 3;
  localparam int ROW_MAJOR = 0;
  localparam int CW        = NUM_CH * CH_W;

  logic            sclk = 1'b0;
  logic            rsrt;
  logic            blk_valid;
  logic            blk_ready;
  logic            blk_alpha;
  logic [CW-1:0]   blk_c0, blk_c1, blk_c2;
`ifdef ETC_PLANAR_PIX_MASK_EN
  logic [15:0]     pix_mask;
`endif
  logic            pix_valid;
  logic            pix_ready = 1'b1;
  logic [3:0]      pix_idx;
  logic [CW-1:0]   pix_color;
  logic [CH_W-1:0] pix_a;
  logic            pix_last;

  etc_planar_block_generator #(
    .CH_W(CH_W), .NUM_CH(NUM_CH), .ROW_MAJOR(ROW_MAJOR)
  ) dut (
    .sclk(sclk), .rsrt(rsrt),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_alpha(blk_alpha),
    .blk_c0(blk_c0), .blk_c1(blk_c1), .blk_c2(blk_c2),
`ifdef ETC_PLANAR_PIX_MASK_EN
    .pix_mask(pix_mask),
`endif
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_idx(pix_idx),
    .pix_color(pix_color), .pix_a(pix_a), .pix_last(pix_last)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int              cyc;
    logic [3:0]      idx;
    logic [CW-1:0]   color;
    logic [CH_W-1:0] a;
    logic            last;
  } pix_t;

  pix_t out_q[$];
  int   acc_q[$];

  // Record every pixel transfer and every block acceptance.
  always @(negedge sclk) begin
    if (pix_valid && pix_ready) out_q.push_back('{cyc, pix_idx, pix_color, pix_a, pix_last});
    if (blk_valid && blk_ready && !rsrt) acc_q.push_back(cyc + 1);
  end

  // pix_ready driver: forced level or random back-pressure.
  bit rdy_rand = 1'b0;
  bit rdy_val  = 1'b1;
  always @(posedge sclk) begin
    #2;
    pix_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: planar interpolation from the base colours, by arithmetic.
  function automatic logic [CW-1:0] model_color(input logic [CW-1:0] o, h, v, input int p);
    int x, y, oo, hh, vv, s, q;
    logic [CW-1:0] r;
    r = '0;
    x = p / 4;
    y = p % 4;
    for (int k = 0; k < NUM_CH; k++) begin
      oo = int'(o[k*CH_W +: CH_W]);
      hh = int'(h[k*CH_W +: CH_W]);
      vv = int'(v[k*CH_W +: CH_W]);
      s  = x * (hh - oo) + y * (vv - oo) + 4 * oo + 2;
      q  = (s >= 0) ? s / 4 : -((3 - s) / 4);
      if (q < 0) q = 0;
      if (q > (1 << CH_W) - 1) q = (1 << CH_W) - 1;
      r[k*CH_W +: CH_W] = q[CH_W-1:0];
    end
    return r;
  endfunction

  function automatic int p_of_n(input int n);
    return (ROW_MAJOR != 0) ? (n % 4) * 4 + n / 4 : n;
  endfunction

  function automatic logic [CW-1:0] rep(input logic [7:0] c);
    return {c, c, c};
  endfunction

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic send_block(input logic [CW-1:0] o, h, v, input logic a);
    int guard;
    guard = 0;
    while (!blk_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("blk_ready_before_send", blk_ready, 1'b1);
    blk_c0 = o; blk_c1 = h; blk_c2 = v; blk_alpha = a;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic wait_pix(input int n, input string name);
    int guard;
    guard = 0;
    while (out_q.size() < n && guard < 400) begin
      tick();
      guard++;
    end
    check(name, (out_q.size() >= n), 1'b1);
  endtask

  task automatic check_block(input int base, input logic [CW-1:0] o, h, v,
                             input logic a, input string tag);
    for (int n = 0; n < 16; n++) begin
      if (base + n < out_q.size()) begin
        check($sformatf("%s_idx%0d", tag, n), out_q[base+n].idx, p_of_n(n));
        check($sformatf("%s_col%0d", tag, n), out_q[base+n].color, model_color(o, h, v, p_of_n(n)));
        check($sformatf("%s_a%0d", tag, n), out_q[base+n].a, a ? 8'hFF : 8'h00);
        check($sformatf("%s_last%0d", tag, n), out_q[base+n].last, (n == 15));
      end else begin
        check($sformatf("%s_missing%0d", tag, n), 1'b0, 1'b1);
      end
    end
  endtask

  typedef struct {
    logic [CW-1:0]   o, h, v;
    logic            a;
    int              p;
    logic [CW-1:0]   exp_c;
    logic [CH_W-1:0] exp_a;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int base, a0, n0, guard, found;
    logic [CW-1:0] ro, rh, rv, hold_c;
    logic ra, bad;

    tbl[0] = '{rep(8'd100), rep(8'd104), rep(8'd96), 1'b1, 5,  rep(8'd100), 8'hFF};
    tbl[1] = '{rep(8'd100), rep(8'd104), rep(8'd96), 1'b1, 12, rep(8'd103), 8'hFF};
    tbl[2] = '{rep(8'd100), rep(8'd104), rep(8'd96), 1'b1, 0,  rep(8'd100), 8'hFF};
    tbl[3] = '{rep(8'd250), rep(8'd255), rep(8'd255), 1'b0, 15, rep(8'd255), 8'h00};
    tbl[4] = '{rep(8'd2),   rep(8'd0),   rep(8'd0),   1'b0, 15, rep(8'd0),   8'h00};
    tbl[5] = '{rep(8'd2),   rep(8'd0),   rep(8'd0),   1'b0, 0,  rep(8'd2),   8'h00};
    tbl[6] = '{{8'd50, 8'd200, 8'd10}, {8'd50, 8'd100, 8'd20}, {8'd60, 8'd250, 8'd0},
               1'b1, 9, {8'd53, 8'd163, 8'd13}, 8'hFF};

    // Reset, with a block offered at the same time: reset must win.
    rsrt = 1'b1;
    blk_valid = 1'b1;
    blk_alpha = 1'b1;
    blk_c0 = rep(8'd10); blk_c1 = rep(8'd20); blk_c2 = rep(8'd30);
`ifdef ETC_PLANAR_PIX_MASK_EN
    pix_mask = 16'hFFFF;
`endif
    repeat (3) tick();
    check("rst_blk_ready", blk_ready, 1'b1);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_pix_last", pix_last, 1'b0);
    check("rst_pix_idx", pix_idx, 4'd0);
    check("rst_pix_color", pix_color, {CW{1'b0}});
    check("rst_pix_a", pix_a, 8'h00);
    rsrt = 1'b0;
    blk_valid = 1'b0;
    repeat (10) tick();
    check("rst_wins_no_pix", out_q.size(), 0);
    check("rst_wins_no_acc", acc_q.size(), 0);
    check("rst_wins_ready", blk_ready, 1'b1);

    // Nominal block: ordering, latency, consecutive pixels, pix_last.
    base = out_q.size();
    a0 = acc_q.size();
    send_block(rep(8'd100), rep(8'd104), rep(8'd96), 1'b1);
    wait_pix(base + 16, "nom_arrive");
    check_block(base, rep(8'd100), rep(8'd104), rep(8'd96), 1'b1, "nom");
    if (acc_q.size() > a0 && out_q.size() >= base + 16) begin
      check("nom_latency", out_q[base].cyc - acc_q[a0], 2);
      check("nom_consecutive", out_q[base+15].cyc - out_q[base].cyc, 15);
    end else begin
      check("nom_accept_seen", 1'b0, 1'b1);
    end

    // Table vectors: specific pixels of specific blocks.
    for (int i = 0; i < 7; i++) begin
      base = out_q.size();
      send_block(tbl[i].o, tbl[i].h, tbl[i].v, tbl[i].a);
      wait_pix(base + 16, $sformatf("tbl%0d_arrive", i));
      found = 0;
      hold_c = '0;
      ra = 1'b0;
      for (int n = 0; n < 16; n++) begin
        if (base + n < out_q.size() && out_q[base+n].idx == tbl[i].p) begin
          found = 1;
          hold_c = out_q[base+n].color;
          ra = (out_q[base+n].a == tbl[i].exp_a);
        end
      end
      check($sformatf("tbl%0d_found", i), found, 1);
      check($sformatf("tbl%0d_color", i), hold_c, tbl[i].exp_c);
      check($sformatf("tbl%0d_alpha", i), ra, 1'b1);
    end

    // Back-pressure: stall while pixel 3 is presented.
    ro = {8'd90, 8'd60, 8'd30}; rh = {8'd200, 8'd10, 8'd90}; rv = {8'd120, 8'd255, 8'd0};
    base = out_q.size();
    send_block(ro, rh, rv, 1'b0);
    guard = 0;
    while (!(pix_valid && pix_idx == 4'd3) && guard < 50) begin
      tick();
      guard++;
    end
    check("bp_reach_p3", (pix_valid && pix_idx == 4'd3), 1'b1);
    rdy_val = 1'b0;
    hold_c = pix_color;
    check("bp_hold_model", hold_c, model_color(ro, rh, rv, 3));
    repeat (5) begin
      tick();
      check("bp_valid_held", pix_valid, 1'b1);
      check("bp_idx_held", pix_idx, 4'd3);
      check("bp_color_held", pix_color, hold_c);
    end
    rdy_val = 1'b1;
    wait_pix(base + 16, "bp_arrive");
    repeat (5) tick();
    check("bp_count", out_q.size() - base, 16);
    check_block(base, ro, rh, rv, 1'b0, "bp");

    // Back-to-back blocks with blk_valid held high.
    ro = {8'd5, 8'd128, 8'd77}; rh = {8'd9, 8'd140, 8'd70};
    rv = {8'd1, 8'd120, 8'd90};
    base = out_q.size();
    a0 = acc_q.size();
    blk_c0 = ro; blk_c1 = rh; blk_c2 = rv; blk_alpha = 1'b1;
    blk_valid = 1'b1;
    tick();
    check("b2b_first_taken", blk_ready, 1'b0);
    blk_c0 = rv; blk_c1 = ro; blk_c2 = rh; blk_alpha = 1'b0;
    guard = 0;
    while (!blk_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    blk_valid = 1'b0;
    wait_pix(base + 32, "b2b_arrive");
    if (acc_q.size() >= a0 + 2 && out_q.size() >= base + 32) begin
      check("b2b_period", acc_q[a0+1] - acc_q[a0], 17);
      check("b2b_gap", out_q[base+16].cyc - out_q[base+15].cyc, 2);
    end else begin
      check("b2b_accepts_seen", 1'b0, 1'b1);
    end
    check_block(base, ro, rh, rv, 1'b1, "b2bA");
    check_block(base + 16, rv, ro, rh, 1'b0, "b2bB");

    // Reset while pixel 7 is on the output.
    base = out_q.size();
    send_block(rep(8'd40), rep(8'd80), rep(8'd20), 1'b1);
    guard = 0;
    while (!(pix_valid && pix_idx == 4'd7) && guard < 50) begin
      tick();
      guard++;
    end
    check("mrst_reach_p7", (pix_valid && pix_idx == 4'd7), 1'b1);
    rsrt = 1'b1;
    tick();
    rsrt = 1'b0;
    check("mrst_pix_valid", pix_valid, 1'b0);
    check("mrst_blk_ready", blk_ready, 1'b1);
    n0 = out_q.size();
    check("mrst_emitted", n0 - base, 8);
    repeat (25) tick();
    check("mrst_no_residual", out_q.size(), n0);

    // Recovery after the mid-block reset.
    base = out_q.size();
    send_block(rep(8'd100), rep(8'd104), rep(8'd96), 1'b1);
    wait_pix(base + 16, "recov_arrive");
    check_block(base, rep(8'd100), rep(8'd104), rep(8'd96), 1'b1, "recov");

    // Random blocks under random back-pressure.
    rdy_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      ro = CW'($urandom); rh = CW'($urandom); rv = CW'($urandom);
      ra = 1'($urandom);
      base = out_q.size();
      send_block(ro, rh, rv, ra);
      wait_pix(base + 16, $sformatf("rnd%0d_arrive", r));
      check_block(base, ro, rh, rv, ra, $sformatf("rnd%0d", r));
    end
    rdy_rand = 1'b0;
    repeat (3) tick();

`ifdef ETC_PLANAR_PIX_MASK_EN
    // Sparse mask: only p=0 and p=15, back to back.
    pix_mask = 16'h8001;
    base = out_q.size();
    send_block(rep(8'd250), rep(8'd255), rep(8'd255), 1'b1);
    wait_pix(base + 2, "mask_arrive");
    repeat (10) tick();
    check("mask_count", out_q.size() - base, 2);
    if (out_q.size() >= base + 2) begin
      check("mask_idx0", out_q[base].idx, 4'd0);
      check("mask_last0", out_q[base].last, 1'b0);
      check("mask_col0", out_q[base].color, rep(8'd250));
      check("mask_idx1", out_q[base+1].idx, 4'd15);
      check("mask_last1", out_q[base+1].last, 1'b1);
      check("mask_col1", out_q[base+1].color, rep(8'd255));
      check("mask_adjacent", out_q[base+1].cyc - out_q[base].cyc, 1);
    end
    // Empty mask: accepted, nothing emitted, stays ready.
    pix_mask = 16'h0000;
    base = out_q.size();
    a0 = acc_q.size();
    send_block(rep(8'd1), rep(8'd2), rep(8'd3), 1'b1);
    bad = 1'b0;
    repeat (10) begin
      if (!blk_ready) bad = 1'b1;
      tick();
    end
    check("mask0_ready", bad, 1'b0);
    check("mask0_accepted", acc_q.size() - a0, 1);
    check("mask0_no_pix", out_q.size() - base, 0);
    pix_mask = 16'hFFFF;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
